// File: rtl/dma_ch_programmer.sv
// Host-side sequencer that arms one 8237A-style DMA channel through its CPU register port
// and optionally polls the status register until that channel reports terminal count.
module dma_ch_programmer #(
    parameter int STROBE_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        start,
    input  logic [1:0]  ch,
    input  logic [15:0] base_addr,
    input  logic [15:0] word_count,
    input  logic [5:0]  mode_bits,
    input  logic        cmd_wr_en,
    input  logic [7:0]  cmd_byte,
    input  logic        poll_en,
    input  logic        abort,
    input  logic [7:0]  db_in,
    output logic        cs_n,
    output logic        ior_n,
    output logic        iow_n,
    output logic [3:0]  a_out,
    output logic [7:0]  db_out,
    output logic        db_oe,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  status_q
);

    localparam int CNT_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STROBE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_STROBE   = 3'd2,
        ST_HOLD     = 3'd3,
        ST_POLL_GAP = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    state_t           state_r;
    logic [CNT_W-1:0] cnt_r;
    logic [2:0]       step_r;
    logic             reading_r;
    logic             polled_r;
    logic             aborted_r;
    logic [1:0]       ch_r;
    logic [15:0]      base_r;
    logic [15:0]      wc_r;
    logic [5:0]       mode_r;
    logic [7:0]       cmd_r;
    logic             poll_en_r;

    logic             cs_n_r;
    logic             ior_n_r;
    logic             iow_n_r;
    logic [3:0]       a_r;
    logic [7:0]       dbo_r;
    logic             oe_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic [7:0]       status_r;

    logic [3:0]       bus_a_s;
    logic [7:0]       bus_d_s;

    assign cs_n     = cs_n_r;
    assign ior_n    = ior_n_r;
    assign iow_n    = iow_n_r;
    assign a_out    = a_r;
    assign db_out   = dbo_r;
    assign db_oe    = oe_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;
    assign status_q = status_r;

    // Address/data for the bus cycle currently being sequenced
    always_comb begin
        bus_a_s = 4'h0;
        bus_d_s = 8'h00;
        if (reading_r) begin
            bus_a_s = 4'h8;
            bus_d_s = 8'h00;
        end else begin
            case (step_r)
                3'd0:    begin bus_a_s = 4'h8;                 bus_d_s = cmd_r;           end
                3'd1:    begin bus_a_s = 4'hC;                 bus_d_s = 8'h00;           end
                3'd2:    begin bus_a_s = {1'b0, ch_r, 1'b0};   bus_d_s = base_r[7:0];     end
                3'd3:    begin bus_a_s = {1'b0, ch_r, 1'b0};   bus_d_s = base_r[15:8];    end
                3'd4:    begin bus_a_s = {1'b0, ch_r, 1'b1};   bus_d_s = wc_r[7:0];       end
                3'd5:    begin bus_a_s = {1'b0, ch_r, 1'b1};   bus_d_s = wc_r[15:8];      end
                3'd6:    begin bus_a_s = 4'hB;                 bus_d_s = {mode_r, ch_r};  end
                3'd7:    begin bus_a_s = 4'hA;                 bus_d_s = {6'b000000, ch_r}; end
                default: begin bus_a_s = 4'h0;                 bus_d_s = 8'h00;           end
            endcase
        end
    end

    // Sequencer FSM; bus outputs are registered from the state one clock behind it
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            step_r    <= 3'd0;
            reading_r <= 1'b0;
            polled_r  <= 1'b0;
            aborted_r <= 1'b0;
            ch_r      <= 2'd0;
            base_r    <= 16'h0000;
            wc_r      <= 16'h0000;
            mode_r    <= 6'd0;
            cmd_r     <= 8'h00;
            poll_en_r <= 1'b0;
            cs_n_r    <= 1'b1;
            ior_n_r   <= 1'b1;
            iow_n_r   <= 1'b1;
            a_r       <= 4'h0;
            dbo_r     <= 8'h00;
            oe_r      <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
            status_r  <= 8'h00;
        end else begin
            busy_r <= (state_r != ST_IDLE);
            done_r <= (state_r == ST_DONE);

            case (state_r)
                ST_SETUP: begin
                    cs_n_r  <= 1'b0;
                    ior_n_r <= 1'b1;
                    iow_n_r <= 1'b1;
                    a_r     <= bus_a_s;
                    dbo_r   <= bus_d_s;
                    oe_r    <= ~reading_r;
                end
                ST_STROBE: begin
                    cs_n_r  <= 1'b0;
                    ior_n_r <= ~reading_r;
                    iow_n_r <= reading_r;
                    oe_r    <= ~reading_r;
                end
                ST_HOLD: begin
                    cs_n_r  <= 1'b0;
                    ior_n_r <= 1'b1;
                    iow_n_r <= 1'b1;
                    oe_r    <= ~reading_r;
                end
                default: begin
                    cs_n_r  <= 1'b1;
                    ior_n_r <= 1'b1;
                    iow_n_r <= 1'b1;
                    oe_r    <= 1'b0;
                end
            endcase

            case (state_r)
                ST_IDLE: begin
                    // busy_r still high here means DONE was just left; wait one more clock
                    if (start && !busy_r) begin
                        ch_r      <= ch;
                        base_r    <= base_addr;
                        wc_r      <= word_count;
                        mode_r    <= mode_bits;
                        cmd_r     <= cmd_byte;
                        poll_en_r <= poll_en;
                        step_r    <= cmd_wr_en ? 3'd0 : 3'd1;
                        reading_r <= 1'b0;
                        polled_r  <= 1'b0;
                        aborted_r <= 1'b0;
                        err_r     <= 1'b0;
                        state_r   <= ST_SETUP;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    cnt_r   <= '0;
                    state_r <= ST_STROBE;
                end
                ST_STROBE: begin
                    if (cnt_r == CNT_LAST) begin
                        state_r <= ST_HOLD;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    // This edge closes the last strobe-low clock of a read
                    if (reading_r) begin
                        status_r <= db_in;
                        polled_r <= 1'b1;
                    end
                    if (abort) begin
                        aborted_r <= 1'b1;
                        state_r   <= ST_DONE;
                    end else if (!reading_r && (step_r != 3'd7)) begin
                        step_r  <= step_r + 3'd1;
                        state_r <= ST_SETUP;
                    end else if (poll_en_r) begin
                        reading_r <= 1'b1;
                        state_r   <= ST_POLL_GAP;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                ST_POLL_GAP: begin
                    if (abort) begin
                        aborted_r <= 1'b1;
                        state_r   <= ST_DONE;
                    end else if (polled_r && status_r[ch_r]) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_SETUP;
                    end
                end
                ST_DONE: begin
                    err_r   <= aborted_r;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_ch_programmer.sv
// Directed bench for dma_ch_programmer: write order, command/poll variants, abort, reset
// mid-strobe, and a single-clock-strobe instance.
module tb_dma_ch_programmer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start1;
    logic [1:0]  ch;
    logic [15:0] base_addr;
    logic [15:0] word_count;
    logic [5:0]  mode_bits;
    logic        cmd_wr_en;
    logic [7:0]  cmd_byte;
    logic        poll_en;
    logic        abort;
    logic [7:0]  db_in = 8'h00;

    logic        cs_n, ior_n, iow_n, db_oe, busy, done, err;
    logic [3:0]  a_out;
    logic [7:0]  db_out, status_q;
    logic        cs_n1, ior_n1, iow_n1, db_oe1, busy1, done1, err1;
    logic [3:0]  a_out1;
    logic [7:0]  db_out1, status_q1;

    int vectors = 0;
    int miscompares = 0;

    // Monitor state
    logic [3:0] wr_a [0:63];
    logic [7:0] wr_d [0:63];
    logic       wr_ok [0:63];
    int wr_total = 0;
    int rd_total = 0;
    int rd_bad = 0;
    int both_low = 0;
    int ior_run = 0;
    int ior_last_len = 0;
    logic prev_iow = 1'b1;
    logic prev_ior = 1'b1;
    int rd_base = 0;
    int tc_after = 1000;
    logic [7:0] tc_val = 8'h00;

    logic [11:0] exp_seq [0:6] = '{12'hC00, 12'h434, 12'h412, 12'h5FF, 12'h500, 12'hB46, 12'hA02};

    dma_ch_programmer dut (
        .CLK(clk), .RESET(rst), .start(start), .ch(ch), .base_addr(base_addr),
        .word_count(word_count), .mode_bits(mode_bits), .cmd_wr_en(cmd_wr_en),
        .cmd_byte(cmd_byte), .poll_en(poll_en), .abort(abort), .db_in(db_in),
        .cs_n(cs_n), .ior_n(ior_n), .iow_n(iow_n), .a_out(a_out), .db_out(db_out),
        .db_oe(db_oe), .busy(busy), .done(done), .err(err), .status_q(status_q)
    );

    dma_ch_programmer #(.STROBE_CYCLES(1)) dut1 (
        .CLK(clk), .RESET(rst), .start(start1), .ch(ch), .base_addr(base_addr),
        .word_count(word_count), .mode_bits(mode_bits), .cmd_wr_en(cmd_wr_en),
        .cmd_byte(cmd_byte), .poll_en(poll_en), .abort(abort), .db_in(db_in),
        .cs_n(cs_n1), .ior_n(ior_n1), .iow_n(iow_n1), .a_out(a_out1), .db_out(db_out1),
        .db_oe(db_oe1), .busy(busy1), .done(done1), .err(err1), .status_q(status_q1)
    );

    always #5 clk = ~clk;

    // Bus monitor and status responder, sampled away from the active edge
    always @(negedge clk) begin
        if (iow_n == 1'b0 && ior_n == 1'b0) both_low++;
        if (iow_n == 1'b0 && prev_iow) begin
            wr_a[wr_total % 64]  = a_out;
            wr_d[wr_total % 64]  = db_out;
            wr_ok[wr_total % 64] = (cs_n == 1'b0) && (db_oe == 1'b1);
            wr_total++;
        end
        if (ior_n == 1'b0) begin
            if (prev_ior) begin
                rd_total++;
                if (a_out != 4'h8 || cs_n != 1'b0 || db_oe != 1'b0) rd_bad++;
                db_in = ((rd_total - rd_base) >= tc_after) ? tc_val : 8'h00;
            end
            ior_run++;
        end else if (!prev_ior) begin
            ior_last_len = ior_run;
            ior_run = 0;
        end
        prev_iow = iow_n;
        prev_ior = ior_n;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Pulses start and returns the clock index (after the accepting edge) on which done is seen
    task automatic launch(input logic [1:0] c, input logic [15:0] ba, input logic [15:0] wc,
                          input logic [5:0] mb, input logic cwe, input logic [7:0] cb,
                          input logic pe, output int n);
        @(negedge clk);
        ch = c; base_addr = ba; word_count = wc; mode_bits = mb;
        cmd_wr_en = cwe; cmd_byte = cb; poll_en = pe; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        int b;
        int rb;
        int cnt;
        logic p;

        rst = 1'b1; start = 1'b0; start1 = 1'b0; ch = 2'd0; base_addr = 16'h0000;
        word_count = 16'h0000; mode_bits = 6'd0; cmd_wr_en = 1'b0; cmd_byte = 8'h00;
        poll_en = 1'b0; abort = 1'b0;
        #12;
        check("rst_ctl", {cs_n, ior_n, iow_n, db_oe, busy, done, err}, 32'b1110000);
        check("rst_a_db", {a_out, db_out}, 32'h000);
        check("rst_status", status_q, 32'h00);
        @(negedge clk);
        rst = 1'b0;

        // Plain arming sequence
        b = wr_total; rb = rd_total;
        launch(2'd2, 16'h1234, 16'h00FF, 6'b010001, 1'b0, 8'h00, 1'b0, n);
        check("t1_done_clk", n, 29);
        check("t1_busy_at_done", busy, 1'b1);
        check("t1_err", err, 1'b0);
        check("t1_wr_count", wr_total - b, 7);
        check("t1_rd_count", rd_total - rb, 0);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("t1_wr%0d", i), {wr_a[(b + i) % 64], wr_d[(b + i) % 64]}, exp_seq[i]);
            check($sformatf("t1_ctl%0d", i), wr_ok[(b + i) % 64], 1'b1);
        end

        // Back-to-back with command write
        b = wr_total;
        launch(2'd2, 16'h1234, 16'h00FF, 6'b010001, 1'b1, 8'h04, 1'b0, n);
        check("t2_done_clk", n, 33);
        check("t2_wr_count", wr_total - b, 8);
        check("t2_cmd", {wr_a[b % 64], wr_d[b % 64]}, 12'h804);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("t2_wr%0d", i), {wr_a[(b + 1 + i) % 64], wr_d[(b + 1 + i) % 64]}, exp_seq[i]);
        end
        @(negedge clk);
        check("t2_busy_after", {busy, done}, 2'b00);

        // Polling until TC on channel 1 (third read)
        rd_base = rd_total; tc_after = 3; tc_val = 8'h02; b = wr_total;
        launch(2'd1, 16'hABCD, 16'h0010, 6'b000101, 1'b0, 8'h00, 1'b1, n);
        check("t3_done_clk", n, 45);
        check("t3_reads", rd_total - rd_base, 3);
        check("t3_status", status_q, 8'h02);
        check("t3_err", err, 1'b0);
        check("t3_rd_bus", rd_bad, 0);
        check("t3_wr_count", wr_total - b, 7);
        check("t3_rd_len", ior_last_len, 2);

        // Abort during a read strobe
        repeat (2) @(negedge clk);
        rd_base = rd_total; tc_after = 1000;
        ch = 2'd0; poll_en = 1'b1; cmd_wr_en = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        p = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk); #1;
            if (rd_total - rd_base >= 1) begin
                p = 1'b1;
                break;
            end
        end
        check("t4_read_seen", p, 1'b1);
        abort = 1'b1;
        p = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                p = 1'b1;
                break;
            end
        end
        check("t4_done_seen", p, 1'b1);
        check("t4_err", err, 1'b1);
        check("t4_cs_n", cs_n, 1'b1);
        check("t4_strobe_len", ior_last_len, 2);
        check("t4_reads", rd_total - rd_base, 1);
        abort = 1'b0;
        repeat (3) @(negedge clk);
        check("t4_err_held", {err, done, busy}, 3'b100);

        // Reset during the strobe of the base-address high byte
        b = wr_total;
        ch = 2'd2; base_addr = 16'h1234; word_count = 16'h00FF; mode_bits = 6'b010001;
        poll_en = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check("t5_err_cleared", err, 1'b0);
        p = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk); #1;
            if (wr_total - b >= 3) begin
                p = 1'b1;
                break;
            end
        end
        check("t5_step3_seen", p, 1'b1);
        check("t5_iow_low", iow_n, 1'b0);
        rst = 1'b1;
        #1;
        check("t5_rst_bus", {iow_n, cs_n, busy, done}, 4'b1100);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) cnt++;
        end
        check("t5_no_done", cnt, 0);
        b = wr_total;
        launch(2'd2, 16'h1234, 16'h00FF, 6'b010001, 1'b0, 8'h00, 1'b0, n);
        check("t5_done_clk", n, 29);
        check("t5_wr_count", wr_total - b, 7);
        check("t5_first", {wr_a[b % 64], wr_d[b % 64]}, 12'hC00);
        check("t5_last", {wr_a[(b + 6) % 64], wr_d[(b + 6) % 64]}, 12'hA02);
        check("t5_both_low", both_low, 0);

        // Single-clock strobe instance with an ignored start mid-sequence
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        #1 start1 = 1'b0;
        n = -1; cnt = 0; p = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i == 5) start1 = 1'b1;
            if (i == 6) start1 = 1'b0;
            if (iow_n1 == 1'b0) cnt++;
            if (done1 === 1'b1) begin
                n = i;
                break;
            end
        end
        check("t6_done_clk", n, 22);
        check("t6_wr_clocks", cnt, 7);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i > 0 && (busy1 === 1'b1 || iow_n1 === 1'b0)) cnt++;
        end
        check("t6_no_retrigger", cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dma_ch_programmer.md
# dma_ch_programmer

Host-side initiator for the 8237A CPU register interface: on a single `start` pulse it issues the complete I/O write sequence that arms one DMA channel. The sequence writes the optional command register, clears the byte-pointer flip-flop, and writes base address, word count, mode and single-mask. It can then optionally poll the status register until that channel reports terminal count. It sits between the test/host logic and the DMA block's `CS_N`/`IOR_N`/`IOW_N`/`A[3:0]`/`DB[7:0]` pins, driving the register map the DMA block decodes.

## Interface
- `STROBE_CYCLES`, default 2: clocks `IOR_N`/`IOW_N` are held low per bus cycle (legal range ≥1).
- `CLK` input 1: single clock; all outputs are registered on its rising edge.
- `RESET` input 1: asynchronous, active-high reset.
- `start` input 1: one-cycle request; sampled only in IDLE.
- `ch` input 2: target channel; captured with `start`.
- `base_addr` input 16: base/current address value; captured with `start`.
- `word_count` input 16: base/current word count value; captured with `start`.
- `mode_bits` input 6: MODE_REG[7:2] (mode_sel, addr_inc_dec, auto_init_en, trans_type); captured with `start`.
- `cmd_wr_en` input 1: if 1, write `cmd_byte` first; captured with `start`.
- `cmd_byte` input 8: command register value.
- `poll_en` input 1: if 1, poll status after arming; captured with `start`.
- `abort` input 1: level; terminates polling.
- `db_in` input 8: data bus from the DMA block.
- `cs_n`, `ior_n`, `iow_n` output 1 each: bus controls.
- `a_out` output 4: register address.
- `db_out` output 8: write data.
- `db_oe` output 1: write-data enable.
- `busy` output 1: sequence in progress.
- `done` output 1: one-cycle completion pulse.
- `err` output 1: completion was caused by abort; valid with `done`.
- `status_q` output 8: last status byte read.

## Operation
Write sequence, skipping step 0 when `cmd_wr_en=0`:
- Step 0: `A=8`, data=`cmd_byte`.
- Step 1: `A=C`, data=8'h00 (clear byte-pointer flip-flop).
- Step 2: `A={ch,0}`, data=`base_addr[7:0]`.
- Step 3: `A={ch,0}`, data=`base_addr[15:8]`.
- Step 4: `A={ch,1}`, data=`word_count[7:0]`.
- Step 5: `A={ch,1}`, data=`word_count[15:8]`.
- Step 6: `A=B`, data=`{mode_bits,ch}`.
- Step 7: `A=A`, data=`{5'b0,1'b0,ch}` (unmask channel).

Polling (`poll_en=1`):
- Repeated read cycles at `A=8`.
- `db_in` is captured into `status_q` on the last strobe-low clock.
- Exit when `status_q[ch]` (the TC bit) is 1.
- One idle clock separates consecutive polls.

FSM states and transitions:
- `IDLE`: `start` → `SETUP`.
- `SETUP` (1 clk) → `STROBE`.
- `STROBE` (`STROBE_CYCLES` clk) → `HOLD`.
- `HOLD` (1 clk) → `SETUP` if write steps remain; otherwise `POLL_GAP` if `poll_en=1`; otherwise `DONE`.
- `POLL_GAP` → `SETUP` for the next read, or `DONE`.
- `DONE` (1 clk) → `IDLE`.

Abort:
- Sampled only in `HOLD` or `POLL_GAP`, never mid-strobe.
- When seen, the FSM goes to `DONE` with `err=1`. Remaining write steps are not issued.

Other rules:
- `start` while `busy=1` is ignored. Inputs are not re-sampled.
- Bus values in each state:
  - `SETUP`: `cs_n=0`, `a_out`/`db_out` valid, `db_oe=1` on writes.
  - `STROBE`: `iow_n=0` or `ior_n=0`.
  - `HOLD`: strobe high, `cs_n=0`, address/data unchanged.
  - `IDLE`/`POLL_GAP`/`DONE`: `cs_n=1`, `db_oe=0`.
- `iow_n` and `ior_n` are never low together.

## Timing
- Reset values: `cs_n`=1, `ior_n`=1, `iow_n`=1, `a_out`=0, `db_out`=0, `db_oe`=0, `busy`=0, `done`=0, `err`=0, `status_q`=0. FSM resets to `IDLE`.
- `RESET` mid-cycle deasserts strobes and `cs_n` immediately. The partial sequence is abandoned and no `done` is produced.
- Bus cycle length: `STROBE_CYCLES`+2 clocks (4 at default).
- `start` sampled high at edge k → `busy`=1 and `SETUP` outputs visible after edge k+1.
- Without command/poll: 7 cycles × 4 = 28 clocks; `done` is high on clock 29 after `start`. `cmd_wr_en` adds 4 clocks.
- Each poll iteration costs `STROBE_CYCLES`+3 clocks.
- `busy` stays high through the `DONE` clock and drops with `done`.
- `err` is cleared on the next accepted `start`.
- Back-to-back: `start` in the clock after `done` is accepted.

## Test plan
- Program: `ch=2`, `base_addr=16'h1234`, `word_count=16'h00FF`, `mode_bits=6'b010001`, no cmd/poll → exactly 7 write cycles in this order:
  - `(C,00)`, `(4,34)`, `(4,12)`, `(5,FF)`, `(5,00)`, `(B,46)`, `(A,02)`;
  - `done` on clock 29; `ior_n` stays 1 throughout.
- Command: `cmd_wr_en=1`, `cmd_byte=8'h04` → first cycle is `(8,04)`, 8 cycles total, `done` at clock 33.
- Poll: `poll_en=1`, `ch=1`, responder returns `status 8'h00` twice then `8'h02` → 3 reads at `A=8`, `status_q=8'h02`, `done` with `err=0`.
- Abort: `abort` asserted during polling while a strobe is low → strobe completes its full `STROBE_CYCLES`, then `done` with `err=1`, `cs_n=1`.
- Reset: `RESET` asserted during the `STROBE` of step 3 → same-cycle `iow_n=1`, `cs_n=1`, `busy=0`, no `done`. A new `start` after release issues the full sequence from step 1.
- `STROBE_CYCLES=1`: ignored `start` while busy does not re-trigger; each write is 3 clocks; 21-clock sequence.
